// File: rtl/imem_loader.sv
// Hex-character stream loader: packs ASCII hex pairs big-endian into 32-bit words
// and writes them to instruction memory. Optional XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              clear,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              imem_ceb,
    output logic              imem_web,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic [15:0]       byte_count,
    output logic              load_error,
    output logic [7:0]        checksum
);

    // state   | meaning
    // ACCEPT  | taking characters, assembling nibbles/bytes into word_q
    // WRITE   | one-cycle write strobe on the memory port
    // DONE    | terminator seen and flushed; idle until clear
    typedef enum logic [1:0] {S_ACCEPT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              hi_pend_q, hi_pend_d;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              full_q, full_d;
    logic              term_q, term_d;

    logic              char_ready_q, char_ready_d;
    logic              imem_ceb_q, imem_ceb_d;
    logic              imem_web_q, imem_web_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              load_done_q, load_done_d;
    logic [15:0]       byte_count_q, byte_count_d;
    logic              load_error_q, load_error_d;

    logic              xfer, is_hex, is_term, commit, start_write;
    logic [3:0]        nib;
    logic [7:0]        commit_byte;
    logic [31:0]       word_new;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        checksum_q, checksum_d;
`endif

    always_comb begin
        is_hex = 1'b1;
        nib    = char_data[3:0];
        if (char_data >= 8'h30 && char_data <= 8'h39) begin
            nib = char_data[3:0];
        end else if ((char_data >= 8'h41 && char_data <= 8'h46) ||
                     (char_data >= 8'h61 && char_data <= 8'h66)) begin
            nib = char_data[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_term = (char_data == 8'h0A) || (char_data == 8'h0D) || (char_data == 8'h04);
    end

    always_comb begin
        state_d      = state_q;
        hi_pend_d    = hi_pend_q;
        hi_nib_d     = hi_nib_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_idx_d   = word_idx_q;
        full_d       = full_q;
        term_d       = term_q;
        imem_ceb_d   = 1'b1;
        imem_web_d   = 1'b1;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = load_done_q;
        byte_count_d = byte_count_q;
        load_error_d = load_error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        xfer         = char_valid && char_ready_q;
        commit       = 1'b0;
        commit_byte  = 8'h00;
        start_write  = 1'b0;
        word_new     = word_q;

        case (state_q)
            S_ACCEPT: begin
                if (xfer) begin
                    if (is_term) begin
                        // an unpaired high nibble becomes a byte with a zero low nibble
                        commit      = hi_pend_q;
                        commit_byte = {hi_nib_q, 4'h0};
                        if (hi_pend_q || byte_idx_q != 2'd0) begin
                            start_write = 1'b1;
                            term_d      = 1'b1;
                        end else begin
                            state_d     = S_DONE;
                            load_done_d = 1'b1;
                        end
                    end else if (is_hex && !full_q) begin
                        if (!hi_pend_q) begin
                            hi_pend_d = 1'b1;
                            hi_nib_d  = nib;
                        end else begin
                            commit      = 1'b1;
                            commit_byte = {hi_nib_q, nib};
                            start_write = (byte_idx_q == 2'd3);
                        end
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
                if (commit) begin
                    word_new     = word_q | ({24'h0, commit_byte} << {~byte_idx_q, 3'b000});
                    word_d       = word_new;
                    byte_idx_d   = byte_idx_q + 2'd1;
                    hi_pend_d    = 1'b0;
                    byte_count_d = byte_count_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d   = checksum_q ^ commit_byte;
`endif
                end
                if (start_write) begin
                    state_d      = S_WRITE;
                    byte_idx_d   = 2'd0;
                    imem_ceb_d   = 1'b0;
                    imem_web_d   = 1'b0;
                    imem_addr_d  = word_idx_q;
                    imem_wdata_d = word_new;
                end
            end
            S_WRITE: begin
                word_d = 32'h0;
                // the index parks on the last word so the address can never wrap
                if (word_idx_q == LAST_IDX) begin
                    full_d = 1'b1;
                end else begin
                    word_idx_d = word_idx_q + IDX_ONE;
                end
                if (term_q) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                    term_d      = 1'b0;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: begin
            end
        endcase

        char_ready_d = (state_d == S_ACCEPT);

        if (clear) begin
            state_d      = S_ACCEPT;
            hi_pend_d    = 1'b0;
            hi_nib_d     = 4'h0;
            byte_idx_d   = 2'd0;
            word_d       = 32'h0;
            word_idx_d   = '0;
            full_d       = 1'b0;
            term_d       = 1'b0;
            char_ready_d = 1'b0;
            imem_ceb_d   = 1'b1;
            imem_web_d   = 1'b1;
            imem_addr_d  = '0;
            imem_wdata_d = 32'h0;
            load_done_d  = 1'b0;
            byte_count_d = 16'h0;
            load_error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q      <= S_ACCEPT;
            hi_pend_q    <= 1'b0;
            hi_nib_q     <= 4'h0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'h0;
            word_idx_q   <= '0;
            full_q       <= 1'b0;
            term_q       <= 1'b0;
            char_ready_q <= 1'b0;
            imem_ceb_q   <= 1'b1;
            imem_web_q   <= 1'b1;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
            load_done_q  <= 1'b0;
            byte_count_q <= 16'h0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_pend_q    <= hi_pend_d;
            hi_nib_q     <= hi_nib_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_idx_q   <= word_idx_d;
            full_q       <= full_d;
            term_q       <= term_d;
            char_ready_q <= char_ready_d;
            imem_ceb_q   <= imem_ceb_d;
            imem_web_q   <= imem_web_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            load_done_q  <= load_done_d;
            byte_count_q <= byte_count_d;
            load_error_q <= load_error_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end
    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign char_ready = char_ready_q;
    assign imem_ceb   = imem_ceb_q;
    assign imem_web   = imem_web_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign load_done  = load_done_q;
    assign byte_count = byte_count_q;
    assign load_error = load_error_q;

endmodule
